// File: rtl/fc_pkg.sv
// fc_pkg: shared layer dimensions, address width and sequencer state encoding
package fc_pkg;
  localparam int N_CH = 12;
  localparam int IMG_SZ = 16;
  localparam int N_OUT = 10;
  localparam int FC_LEN = N_CH * IMG_SZ;
  localparam int W_AW = $clog2(N_OUT * FC_LEN);
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_STREAM, S_DRAIN, S_WRITE, S_DONE} state_t;
endpackage

// File: rtl/fc_sched_if.sv
// fc_sched_if: control and address bundle between the FC sequencer and its memories/MAC
interface fc_sched_if;
  import fc_pkg::*;
  logic start, stall;
  logic [3:0] p2_addr, p2_ch, res_addr;
  logic [W_AW-1:0] w_addr;
  logic mac_clr, mac_en, res_we, busy, done;
  modport master(input start, stall, output p2_addr, p2_ch, w_addr, mac_clr, mac_en, res_we, res_addr, busy, done);
  modport slave(output start, stall, input p2_addr, p2_ch, w_addr, mac_clr, mac_en, res_we, res_addr, busy, done);
endinterface

// File: rtl/fc_sched_valid_pipe.sv
// valid_pipe: RD_LAT-deep delay line aligning the issue strobe with memory read data
module valid_pipe #(parameter int RD_LAT = 2) (
  input  logic clk,
  input  logic reset,
  input  logic in_v,
  output logic out_v
);
  logic [RD_LAT-1:0] sr;
  always_ff @(posedge clk) sr <= reset ? '0 : RD_LAT'({sr, in_v});
  assign out_v = sr[RD_LAT-1];
endmodule

// File: rtl/fc_sched.sv
// fc_sched: walks pooling-2 memory once per output neuron, driving weight addresses, MAC control and result writes
module fc_sched import fc_pkg::*; #(parameter int RD_LAT = 2) (
  input logic clk,
  input logic reset,
  fc_sched_if.master bus
);
  state_t state;
  logic [3:0] pix, ch, out_idx;
  logic [W_AW-1:0] w_addr;
  logic [7:0] d;
  logic mac_clr, res_we, busy, done;
  logic issue, pix_last, last;
  assign issue = state == S_STREAM && !bus.stall;
  assign pix_last = pix == 4'(IMG_SZ - 1);
  assign last = pix_last && ch == 4'(N_CH - 1);
  assign bus.p2_addr = pix;
  assign bus.p2_ch = ch;
  assign bus.w_addr = w_addr;
  assign bus.res_addr = out_idx;
  assign bus.mac_clr = mac_clr;
  assign bus.res_we = res_we;
  assign bus.busy = busy;
  assign bus.done = done;
  valid_pipe #(.RD_LAT(RD_LAT)) u_vp (.clk(clk), .reset(reset), .in_v(issue), .out_v(bus.mac_en));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      {pix, ch, out_idx, w_addr, d} <= '0;
      {mac_clr, res_we, busy, done} <= '0;
    end else begin
      mac_clr <= 1'b0;
      res_we <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          state <= S_CLR;
          mac_clr <= 1'b1;
          busy <= 1'b1;
        end
        S_CLR: begin
          state <= S_STREAM;
          pix <= '0;
          ch <= '0;
        end
        S_STREAM: if (issue) begin
          // the final issue leaves addresses parked so DRAIN shows the last read
          if (last) begin
            state <= S_DRAIN;
            d <= '0;
          end else begin
            pix <= pix_last ? '0 : pix + 1'b1;
            ch <= pix_last ? ch + 1'b1 : ch;
            w_addr <= w_addr + 1'b1;
          end
        end
        S_DRAIN: if (d == 8'(RD_LAT - 1)) begin
          state <= S_WRITE;
          res_we <= 1'b1;
        end else d <= d + 1'b1;
        S_WRITE: if (out_idx == 4'(N_OUT - 1)) begin
          state <= S_DONE;
          done <= 1'b1;
        end else begin
          state <= S_CLR;
          mac_clr <= 1'b1;
          out_idx <= out_idx + 1'b1;
          w_addr <= w_addr + 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy <= 1'b0;
          {pix, ch, out_idx, w_addr} <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_sched.sv
// tb_fc_sched: randomized scoreboard bench; driver walks the pass timeline and queues expected events
module tb_fc_sched;
  import fc_pkg::*;
  parameter int RD_LAT = 2;
  typedef struct {int cyc; int ch; int pix; int w;} iss_t;
  typedef struct {int cyc; int addr;} ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  fc_sched_if bus();
  fc_sched #(.RD_LAT(RD_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int cyc = 0, checks = 0, errors = 0, mac_cnt = 0;
  bit armed = 0, exp_busy = 0;
  iss_t exp_iss[$];
  ev_t exp_clr[$], exp_wr[$], exp_done[$];
  iss_t ie;
  ev_t ee;
  int h_ch[16], h_pix[16], h_w[16];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic rnd_stall(int pct);
    return pct > 0 && $urandom_range(1) == 1;
  endfunction
  always @(negedge clk) if (armed) begin
    h_ch[cyc % 16] = int'(bus.p2_ch);
    h_pix[cyc % 16] = int'(bus.p2_addr);
    h_w[cyc % 16] = int'(bus.w_addr);
    chk("busy", int'(bus.busy), int'(exp_busy));
    if (!exp_busy)
      chk("idle_outputs", int'({bus.p2_addr, bus.p2_ch, bus.w_addr, bus.mac_clr, bus.mac_en, bus.res_we, bus.res_addr, bus.done}), 0);
    if (bus.mac_en) begin
      mac_cnt++;
      if (exp_iss.size() == 0) chk("mac_en_unexpected", 1, 0);
      else begin
        ie = exp_iss.pop_front();
        chk("mac_en_cycle", cyc, ie.cyc);
        chk("issue_ch", h_ch[(cyc - RD_LAT) % 16], ie.ch);
        chk("issue_pix", h_pix[(cyc - RD_LAT) % 16], ie.pix);
        chk("issue_w_addr", h_w[(cyc - RD_LAT) % 16], ie.w);
      end
    end
    if (bus.mac_clr) begin
      chk("mac_cnt_at_clr", mac_cnt, 0);
      if (exp_clr.size() == 0) chk("mac_clr_unexpected", 1, 0);
      else begin
        ee = exp_clr.pop_front();
        chk("mac_clr_cycle", cyc, ee.cyc);
      end
    end
    if (bus.res_we) begin
      chk("mac_en_per_neuron", mac_cnt, FC_LEN);
      mac_cnt = 0;
      if (exp_wr.size() == 0) chk("res_we_unexpected", 1, 0);
      else begin
        ee = exp_wr.pop_front();
        chk("res_we_cycle", cyc, ee.cyc);
        chk("res_addr", int'(bus.res_addr), ee.addr);
      end
    end
    if (bus.done) begin
      if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        ee = exp_done.pop_front();
        chk("done_cycle", cyc, ee.cyc);
      end
    end
  end
  // entered in the cycle where start is already high; returns in the cycle after DONE (or after a reset abort)
  task automatic run_pass(int pct, int mid_n, int abort_n, bit hold);
    int s, nst;
    s = cyc;
    nst = 0;
    step();
    bus.start = 1'b0;
    exp_busy = 1'b1;
    for (int n = 0; n < N_OUT; n++) begin
      exp_clr.push_back('{cyc, 0});
      bus.stall = rnd_stall(pct);
      step();
      for (int i = 0; i < FC_LEN;) begin
        if (n == abort_n && i == 99) begin
          reset = 1'b1;
          bus.stall = 1'b0;
          step();
          reset = 1'b0;
          exp_busy = 1'b0;
          exp_iss.delete();
          exp_clr.delete();
          mac_cnt = 0;
          for (int k = 0; k < RD_LAT; k++) begin
            chk("mac_en_after_reset", int'(bus.mac_en), 0);
            chk("busy_after_reset", int'(bus.busy), 0);
            step();
          end
          return;
        end
        bus.start = n == mid_n && i == 50;
        if ($urandom_range(99) < pct) begin
          bus.stall = 1'b1;
          nst++;
        end else begin
          bus.stall = 1'b0;
          exp_iss.push_back('{cyc + RD_LAT, i / IMG_SZ, i % IMG_SZ, n * FC_LEN + i});
          i++;
        end
        step();
      end
      bus.start = 1'b0;
      for (int k = 0; k < RD_LAT; k++) begin
        bus.stall = rnd_stall(pct);
        step();
      end
      exp_wr.push_back('{cyc, n});
      bus.stall = rnd_stall(pct);
      step();
    end
    exp_done.push_back('{s + 1 + N_OUT * (194 + RD_LAT) + nst, 0});
    bus.start = hold;
    bus.stall = 1'b0;
    step();
    exp_busy = 1'b0;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.stall = 1'b0;
    repeat (3) step();
    armed = 1'b1;
    reset = 1'b0;
    step();
    bus.start = 1'b1;
    run_pass(0, -1, -1, 1'b0);
    step();
    bus.start = 1'b1;
    run_pass(30, -1, -1, 1'b0);
    step();
    bus.start = 1'b1;
    run_pass(0, 2, -1, 1'b1);
    run_pass(0, -1, -1, 1'b0);
    step();
    bus.start = 1'b1;
    run_pass(10, -1, 5, 1'b0);
    step();
    step();
    bus.start = 1'b1;
    run_pass(0, -1, -1, 1'b0);
    repeat (RD_LAT + 3) step();
    chk("pending_issues", exp_iss.size(), 0);
    chk("pending_clr", exp_clr.size(), 0);
    chk("pending_writes", exp_wr.size(), 0);
    chk("pending_done", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
